request_assembler: RTL and testbench

- Sits between the UART receiver and the main state machine, directly upstream of the decoder/FSM path.
- Collects two-byte PC requests from the UART RX byte stream: first an opcode byte, then an address byte.
- Applies an inter-byte timeout and range-checks both bytes.
- Presents each accepted request on a valid/ready handshake to the FSM; malformed input is reported with an error pulse and code.

---
 rtl/request_assembler_pkg.sv | 18 +
 rtl/request_assembler_timeout_counter.sv | 38 +++
 rtl/request_assembler.sv | 138 +++++++++++++
 tb/tb_request_assembler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/request_assembler_pkg.sv
// rtl/request_assembler_pkg.sv - shared opcode width, error codes and state encoding
// The downstream decoder and FSM import OP_W from here so the opcode width stays in one place.
package request_assembler_pkg;

   localparam int OP_W = 3;

   localparam logic [1:0] ERR_OVERRUN  = 2'b00;
   localparam logic [1:0] ERR_BAD_OP   = 2'b01;
   localparam logic [1:0] ERR_BAD_ADDR = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   typedef enum logic [1:0] {
      WAIT_OP   = 2'd0,
      WAIT_ADDR = 2'd1,
      HOLD      = 2'd2
   } state_t;

endpackage

// File: rtl/request_assembler_timeout_counter.sv
// rtl/request_assembler_timeout_counter.sv - saturating inter-byte timeout counter
// expired is high while the count sits at TIMEOUT_CYCLES-1; clear wins over enable.
module request_assembler_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 2_500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == LAST);

endmodule

// File: rtl/request_assembler.sv
// rtl/request_assembler.sv - assembles opcode/address byte pairs from UART RX into FSM requests
// All outputs are registered; a held request blocks new bytes, which are reported as overruns.
module request_assembler
   import request_assembler_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2_500_000,
   parameter int MAX_OPCODE     = 7,
   parameter int NUM_SENSORS    = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rx_rdy,
   input  logic [7:0]      rx_data,
   output logic            rdy_clr,
   input  logic            req_ready,
   output logic            req_valid,
   output logic [OP_W-1:0] req_instr,
   output logic [7:0]      req_addr,
   output logic            err_valid,
   output logic [1:0]      err_code
);

   state_t          state_q, state_d;
   logic [7:0]      op_q, op_d;
   logic            rdy_clr_q, rdy_clr_d;
   logic            req_valid_q, req_valid_d;
   logic [OP_W-1:0] req_instr_q, req_instr_d;
   logic [7:0]      req_addr_q, req_addr_d;
   logic            err_valid_q, err_valid_d;
   logic [1:0]      err_code_q, err_code_d;

   logic cnt_clr;
   logic cnt_en;
   logic expired;
   logic op_ok;
   logic addr_ok;

   request_assembler_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .expired(expired)
   );

   // Widened to 32 bits so the range checks stay meaningful for any parameter value.
   assign op_ok   = (op_q[7:3] == 5'd0) && ({29'd0, op_q[2:0]} <= 32'(MAX_OPCODE));
   assign addr_ok = ({24'd0, rx_data} < 32'(NUM_SENSORS));
   assign cnt_en  = (state_q == WAIT_ADDR);

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      rdy_clr_d   = rx_rdy;
      req_valid_d = req_valid_q;
      req_instr_d = req_instr_q;
      req_addr_d  = req_addr_q;
      err_valid_d = 1'b0;
      err_code_d  = ERR_OVERRUN;
      cnt_clr     = 1'b0;
      case (state_q)
         WAIT_OP: begin
            if (rx_rdy) begin
               op_d    = rx_data;
               cnt_clr = 1'b1;
               state_d = WAIT_ADDR;
            end
         end
         WAIT_ADDR: begin
            // A byte on the expiry cycle takes precedence over the timeout.
            if (rx_rdy) begin
               state_d = WAIT_OP;
               if (!op_ok) begin
                  err_valid_d = 1'b1;
                  err_code_d  = ERR_BAD_OP;
               end else if (!addr_ok) begin
                  err_valid_d = 1'b1;
                  err_code_d  = ERR_BAD_ADDR;
               end else begin
                  req_valid_d = 1'b1;
                  req_instr_d = op_q[OP_W-1:0];
                  req_addr_d  = rx_data;
                  state_d     = HOLD;
               end
            end else if (expired) begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_TIMEOUT;
               state_d     = WAIT_OP;
            end
         end
         HOLD: begin
            if (rx_rdy) begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_OVERRUN;
            end
            if (req_ready) begin
               req_valid_d = 1'b0;
               state_d     = WAIT_OP;
            end
         end
         default: begin
            state_d = WAIT_OP;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= WAIT_OP;
         op_q        <= 8'd0;
         rdy_clr_q   <= 1'b0;
         req_valid_q <= 1'b0;
         req_instr_q <= '0;
         req_addr_q  <= 8'd0;
         err_valid_q <= 1'b0;
         err_code_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         rdy_clr_q   <= rdy_clr_d;
         req_valid_q <= req_valid_d;
         req_instr_q <= req_instr_d;
         req_addr_q  <= req_addr_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
      end
   end

   assign rdy_clr   = rdy_clr_q;
   assign req_valid = req_valid_q;
   assign req_instr = req_instr_q;
   assign req_addr  = req_addr_q;
   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_request_assembler.sv
// tb/tb_request_assembler.sv - directed and random stimulus against a timestamp-based reference model
module tb_request_assembler;

   localparam int T = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_rdy = 1'b0;
   logic [7:0] rx_data = 8'd0;
   logic       req_ready = 1'b0;
   logic       rdy_clr;
   logic       req_valid;
   logic [2:0] req_instr;
   logic [7:0] req_addr;
   logic       err_valid;
   logic [1:0] err_code;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: a pending opcode is remembered with the edge number it arrived on.
   int         cyc = 0;
   bit         m_pending = 0;
   logic [7:0] m_op = 8'd0;
   int         m_op_cyc = 0;
   bit         m_held = 0;
   logic [2:0] m_instr = 3'd0;
   logic [7:0] m_addr = 8'd0;
   bit         e_rdy_clr = 0;
   bit         e_err = 0;
   logic [1:0] e_code = 2'b00;

   request_assembler #(
      .TIMEOUT_CYCLES(T),
      .MAX_OPCODE    (7),
      .NUM_SENSORS   (32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_rdy   (rx_rdy),
      .rx_data  (rx_data),
      .rdy_clr  (rdy_clr),
      .req_ready(req_ready),
      .req_valid(req_valid),
      .req_instr(req_instr),
      .req_addr (req_addr),
      .err_valid(err_valid),
      .err_code (err_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_pending = 0;
      m_held    = 0;
      m_instr   = 3'd0;
      m_addr    = 8'd0;
      e_rdy_clr = 0;
      e_err     = 0;
      e_code    = 2'b00;
   endtask

   // One clock edge as seen by a PC-protocol observer: pairs of bytes, a deadline of T cycles, one held request.
   task automatic model_step(input bit rx, input logic [7:0] d, input bit rr);
      cyc++;
      e_rdy_clr = rx;
      e_err     = 0;
      e_code    = 2'b00;
      if (m_held) begin
         if (rx) begin
            e_err  = 1;
            e_code = 2'b00;
         end
         if (rr) m_held = 0;
      end else if (m_pending) begin
         if (rx) begin
            m_pending = 0;
            if (m_op >= 8) begin
               e_err  = 1;
               e_code = 2'b01;
            end else if (d >= 32) begin
               e_err  = 1;
               e_code = 2'b10;
            end else begin
               m_held  = 1;
               m_instr = m_op[2:0];
               m_addr  = d;
            end
         end else if (cyc - m_op_cyc == T) begin
            m_pending = 0;
            e_err     = 1;
            e_code    = 2'b11;
         end
      end else if (rx) begin
         m_pending = 1;
         m_op      = d;
         m_op_cyc  = cyc;
      end
   endtask

   task automatic compare_outputs();
      chk("rdy_clr", 32'(rdy_clr), 32'(e_rdy_clr));
      chk("req_valid", 32'(req_valid), 32'(m_held));
      chk("err_valid", 32'(err_valid), 32'(e_err));
      if (e_err) chk("err_code", 32'(err_code), 32'(e_code));
      if (m_held) begin
         chk("req_instr", 32'(req_instr), 32'(m_instr));
         chk("req_addr", 32'(req_addr), 32'(m_addr));
      end
   endtask

   task automatic tick(input bit rx, input logic [7:0] d, input bit rr);
      rx_rdy    = rx;
      rx_data   = d;
      req_ready = rr;
      @(posedge clk);
      if (rst) begin
         cyc++;
         model_reset();
      end else begin
         model_step(rx, d, rr);
      end
      #1;
      compare_outputs();
   endtask

   task automatic idle(input int n, input bit rr);
      for (int i = 0; i < n; i++) tick(0, 8'h00, rr);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rdy_clr"}, 32'(rdy_clr), 32'd0);
      chk({tag, "_req_valid"}, 32'(req_valid), 32'd0);
      chk({tag, "_req_instr"}, 32'(req_instr), 32'd0);
      chk({tag, "_req_addr"}, 32'(req_addr), 32'd0);
      chk({tag, "_err_valid"}, 32'(err_valid), 32'd0);
      chk({tag, "_err_code"}, 32'(err_code), 32'd0);
   endtask

   initial begin
      int gap;
      logic [7:0] b;

      #1;
      check_all_zero("reset");
      idle(3, 1);
      rst = 1'b0;
      idle(2, 1);

      // Basic request, opcode then address ten cycles apart.
      tick(1, 8'h03, 1);
      idle(9, 1);
      tick(1, 8'h05, 1);
      idle(3, 1);

      // Bad opcode, bad address, and the highest legal address.
      tick(1, 8'h09, 1); idle(2, 1); tick(1, 8'h01, 1); idle(3, 1);
      tick(1, 8'h02, 1); idle(2, 1); tick(1, 8'h20, 1); idle(3, 1);
      tick(1, 8'h02, 1); idle(2, 1); tick(1, 8'h1F, 1); idle(3, 1);

      // Timeout with nothing following, then a fresh request.
      tick(1, 8'h01, 1);
      idle(T + 5, 1);
      tick(1, 8'h04, 1); tick(1, 8'h00, 1); idle(3, 1);

      // Second byte exactly on the expiry cycle is accepted.
      tick(1, 8'h01, 1);
      idle(T - 1, 1);
      tick(1, 8'h05, 1);
      idle(3, 1);

      // One cycle late: timeout, and the late byte starts a new request.
      tick(1, 8'h01, 1);
      idle(T, 1);
      tick(1, 8'h03, 1);
      tick(1, 8'h02, 1);
      idle(3, 1);

      // Overrun while held, then transfer; overrun on the transfer cycle itself.
      tick(1, 8'h06, 0); idle(2, 0); tick(1, 8'h02, 0);
      idle(3, 0);
      tick(1, 8'hAA, 0);
      idle(3, 0);
      tick(1, 8'h55, 1);
      idle(3, 1);

      // Async reset while a request is held.
      tick(1, 8'h07, 0); tick(1, 8'h11, 0); idle(2, 0);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("rst_hold");
      tick(0, 8'h00, 0);
      rst = 1'b0;
      model_reset();
      idle(2, 1);

      // Random traffic: mostly legal pairs, some garbage, occasional long gaps and back-pressure.
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 9))
            0:       b = 8'($urandom);
            1:       b = 8'($urandom_range(30, 40));
            default: b = 8'($urandom_range(0, 31));
         endcase
         tick(1, b, 1'($urandom_range(0, 2) != 0));
         gap = ($urandom_range(0, 19) == 0) ? $urandom_range(T - 3, T + 3) : $urandom_range(0, 4);
         for (int g = 0; g < gap; g++) tick(0, 8'h00, 1'($urandom_range(0, 2) != 0));
      end
      idle(5, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
